// File: rtl/seq_subtractor32.sv
// Multi-cycle subtractor: {bout,diff} = a - b - bin, CHUNK bits per cycle, LSB chunk first.
// Optional signed-overflow output enabled by defining SUB_OVERFLOW_EN.
module seq_subtractor32 #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("seq_subtractor32: CHUNK must divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    // Operands and result kept as chunk arrays so the running counter indexes them directly.
    logic [NCH-1:0][CHUNK-1:0] a_r, b_r, diff_r;
    logic [CW-1:0]             cnt;
    logic                      brw_r;
    logic                      bout_r;
    logic                      accept;
    logic                      last;
    logic [CHUNK-1:0]          sub_d;
    logic                      sub_b;

    // One chunk of the borrow chain, evaluated at CHUNK+1 bits so the top bit is the borrow.
    always_comb begin
        {sub_b, sub_d} = {1'b0, a_r[cnt]} - {1'b0, b_r[cnt]} - {{CHUNK{1'b0}}, brw_r};
    end

    assign last   = (cnt == CW'(NCH - 1));
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_nx = RUN;
            end
            RUN: begin
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            cnt    <= '0;
            brw_r  <= 1'b0;
            bout_r <= 1'b0;
        end else begin
            if (accept) begin
                a_r   <= a;
                b_r   <= b;
                brw_r <= bin;
                cnt   <= '0;
            end
            if (state == RUN) begin
                diff_r[cnt] <= sub_d;
                brw_r       <= sub_b;
                cnt         <= cnt + CW'(1);
                if (last) bout_r <= sub_b;
            end
        end
    end

    assign diff = diff_r;
    assign bout = bout_r;

`ifdef SUB_OVERFLOW_EN
    logic ovf_r;

    // The last chunk processed is the top one, so its MSB is the sign of the full difference.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (state == RUN && last) begin
            ovf_r <= (a_r[NCH-1][CHUNK-1] != b_r[NCH-1][CHUNK-1]) &&
                     (sub_d[CHUNK-1] != a_r[NCH-1][CHUNK-1]);
        end
    end

    assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_seq_subtractor32.sv
// Directed-table and random checks for seq_subtractor32 against the 33-bit identity
// {bout,diff} = {0,a} - {0,b} - bin, plus backpressure and mid-operation reset sequences.
module tb_seq_subtractor32;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a, b;
    logic        bin;
    logic        in_ready, out_valid, bout;
    logic [31:0] diff;
    logic        ovf_s;
`ifdef SUB_OVERFLOW_EN
    logic        ovf;
    assign ovf_s = ovf;
`else
    assign ovf_s = 1'b0;
`endif

    seq_subtractor32 #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    logic [31:0] r_diff;
    logic        r_bout, r_ovf, r_bad;
    int          r_lat;

    // One full transaction: accept, scramble inputs, wait for result, stall, then release.
    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_, input logic tbin,
                          input int stall);
        int t;
        logic [32:0] snap;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
        a = ta; b = tb_; bin = tbin; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
        r_lat = 0;
        while (r_lat < 50) begin
            @(negedge clk);
            r_lat++;
            if (out_valid) break;
        end
        if (!out_valid) chk("out_valid_timeout", {63'd0, out_valid}, 64'd1);
        snap  = {bout, diff};
        r_bad = 1'b0;
        repeat (stall) begin
            @(negedge clk);
            if (!out_valid || in_ready || ({bout, diff} !== snap)) r_bad = 1'b1;
        end
        r_diff = diff; r_bout = bout; r_ovf = ovf_s;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[3]  = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[4]  = '{32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0};
        vecs[5]  = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vecs[6]  = '{32'h1234_5678, 32'h0234_5678, 1'b0, 32'h1000_0000, 1'b0, 1'b0};
        vecs[7]  = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[8]  = '{32'h0001_0000, 32'h0000_0000, 1'b1, 32'h0000_FFFF, 1'b0, 1'b0};
        vecs[9]  = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vecs[10] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_result", {31'd0, bout, diff}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed table; latency counts cycles from the accept cycle to the first out_valid cycle.
        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, 0);
            chk($sformatf("vec%0d_result", i), {31'd0, r_bout, r_diff},
                {31'd0, vecs[i].bout, vecs[i].diff});
            chk($sformatf("vec%0d_latency", i), 64'(r_lat), 64'd5);
`ifdef SUB_OVERFLOW_EN
            chk($sformatf("vec%0d_ovf", i), {63'd0, r_ovf}, {63'd0, vecs[i].ovf});
`endif
        end

        // Backpressure: 10 stalled cycles in DONE.
        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 10);
        chk("bp_hold_stable", {63'd0, r_bad}, 64'd0);
        chk("bp_result", {31'd0, r_bout, r_diff}, {31'd0, 1'b0, 32'h0000_00FF});
        @(negedge clk);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);

        // Reset two cycles into RUN, after a partial result has been written.
        a = 32'h0000_0100; b = 32'h0000_0001; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result_cleared", {31'd0, bout, diff}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        begin
            logic seen;
            seen = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (out_valid) seen = 1'b1;
            end
            chk("midrst_no_output", {63'd0, seen}, 64'd0);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0);
        chk("midrst_next_op", {31'd0, r_bout, r_diff}, {31'd0, 1'b1, 32'hFFFF_FFFF});

        // Random vectors with random stalls, checked against the 33-bit identity.
        for (int i = 0; i < 100; i++) begin
            logic [31:0] ra, rb;
            logic        rbin;
            logic [32:0] exp;
            ra   = $urandom;
            rb   = $urandom;
            rbin = 1'($urandom_range(1, 0));
            exp  = {1'b0, ra} - {1'b0, rb} - {32'd0, rbin};
            run_op(ra, rb, rbin, int'($urandom_range(3, 0)));
            chk($sformatf("rand%0d_%h_%h_%0d", i, ra, rb, rbin), {31'd0, r_bout, r_diff},
                {31'd0, exp});
`ifdef SUB_OVERFLOW_EN
            chk($sformatf("rand%0d_ovf", i), {63'd0, r_ovf},
                {63'd0, (ra[31] != rb[31]) && (exp[31] != ra[31])});
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
